// File: rtl/aes_shiftrows_pipe.sv
// Handshaked Rijndael ShiftRows / InvShiftRows stage for Nb = 4/6/8 columns.
// The permutation is applied on entry; a two-entry elastic buffer keeps full throughput.
module aes_shiftrows_pipe #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [32*NB-1:0]    in_data,
    input  logic [1:0]          in_mode,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32*NB-1:0]    out_data,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_err,
    output logic [1:0]          level
);

    localparam int W = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("aes_shiftrows_pipe: NB must be 4, 6 or 8");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("aes_shiftrows_pipe: TAG_W must be at least 1");
    end

    // Rijndael row offsets; only the 256-bit block widens rows 2 and 3.
    function automatic int row_off(input int r);
        int off;
        if (NB == 8 && r >= 2) begin
            off = r + 1;
        end else begin
            off = r;
        end
        return off;
    endfunction

    function automatic logic [W-1:0] shift_rows(input logic [W-1:0] d, input logic [1:0] mode);
        logic [W-1:0] q;
        int           src;
        q = d;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                case (mode)
                    2'b01:   src = (c + row_off(r)) % NB;
                    2'b10:   src = (c + NB - row_off(r)) % NB;
                    default: src = c;
                endcase
                q[W-1-8*(4*c+r) -: 8] = d[W-1-8*(4*src+r) -: 8];
            end
        end
        return q;
    endfunction

    logic [W-1:0]     xf_data_s;
    logic             xf_err_s;
    logic             accept_s;
    logic             pop_s;
    logic             or_valid_r, sr_valid_r, in_ready_r;
    logic [W-1:0]     or_data_r, sr_data_r;
    logic [TAG_W-1:0] or_tag_r, sr_tag_r;
    logic             or_err_r, sr_err_r;
    logic [1:0]       level_r;
    logic             or_valid_n_s, sr_valid_n_s;
    logic             or_load_s, or_from_sr_s, sr_load_s;

    assign xf_data_s = shift_rows(in_data, in_mode);
    assign xf_err_s  = (in_mode == 2'b11);
    assign accept_s  = in_valid & in_ready_r;
    assign pop_s     = or_valid_r & out_ready;

    // Next-state of both entries; flush overrides every other event.
    always_comb begin
        or_valid_n_s = or_valid_r;
        sr_valid_n_s = sr_valid_r;
        or_load_s    = 1'b0;
        or_from_sr_s = 1'b0;
        sr_load_s    = 1'b0;
        if (flush) begin
            or_valid_n_s = 1'b0;
            sr_valid_n_s = 1'b0;
        end else if (or_valid_r && !pop_s) begin
            if (accept_s) begin
                sr_load_s    = 1'b1;
                sr_valid_n_s = 1'b1;
            end else begin
                sr_valid_n_s = sr_valid_r;
            end
        end else if (sr_valid_r) begin
            // in_ready is low here, so no beat can be accepted alongside the refill
            or_from_sr_s = 1'b1;
            or_valid_n_s = 1'b1;
            sr_valid_n_s = 1'b0;
        end else if (accept_s) begin
            or_load_s    = 1'b1;
            or_valid_n_s = 1'b1;
        end else begin
            or_valid_n_s = 1'b0;
        end
    end

    // Buffer state, status flags and payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_valid_r <= 1'b0;
            sr_valid_r <= 1'b0;
            in_ready_r <= 1'b1;
            level_r    <= 2'd0;
            or_data_r  <= '0;
            or_tag_r   <= '0;
            or_err_r   <= 1'b0;
            sr_data_r  <= '0;
            sr_tag_r   <= '0;
            sr_err_r   <= 1'b0;
        end else begin
            or_valid_r <= or_valid_n_s;
            sr_valid_r <= sr_valid_n_s;
            in_ready_r <= !sr_valid_n_s;
            level_r    <= {1'b0, or_valid_n_s} + {1'b0, sr_valid_n_s};
            if (or_from_sr_s) begin
                or_data_r <= sr_data_r;
                or_tag_r  <= sr_tag_r;
                or_err_r  <= sr_err_r;
            end else if (or_load_s) begin
                or_data_r <= xf_data_s;
                or_tag_r  <= in_tag;
                or_err_r  <= xf_err_s;
            end else begin
                or_data_r <= or_data_r;
                or_tag_r  <= or_tag_r;
                or_err_r  <= or_err_r;
            end
            if (sr_load_s) begin
                sr_data_r <= xf_data_s;
                sr_tag_r  <= in_tag;
                sr_err_r  <= xf_err_s;
            end else begin
                sr_data_r <= sr_data_r;
                sr_tag_r  <= sr_tag_r;
                sr_err_r  <= sr_err_r;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = or_valid_r;
    assign out_data  = or_data_r;
    assign out_tag   = or_tag_r;
    assign out_err   = or_err_r;
    assign level     = level_r;

endmodule
